// File: rtl/axil_wr_master.sv
// Buffered AXI4-Lite write master: request FIFO feeding independent AW/W
// issue registers, outstanding-write credit counter and B response reporting.
module axil_wr_master #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_OUTST  = 4
) (
   input  logic                               aclk,
   input  logic                               anreset,
   input  logic                               aenable,
   input  logic                               i_wr_valid,
   output logic                               o_wr_ready,
   input  logic [ADDR_WIDTH-1:0]              i_wr_addr,
   input  logic [DATA_WIDTH-1:0]              i_wr_data,
   input  logic [STRB_WIDTH-1:0]              i_wr_strb,
   output logic [ADDR_WIDTH-1:0]              o_awaddr,
   output logic [2:0]                         o_awprot,
   output logic                               o_awvalid,
   input  logic                               i_awready,
   output logic [DATA_WIDTH-1:0]              o_wdata,
   output logic [STRB_WIDTH-1:0]              o_wstrb,
   output logic                               o_wvalid,
   input  logic                               i_wready,
   input  logic [1:0]                         i_bresp,
   input  logic                               i_bvalid,
   output logic                               o_bready,
   output logic                               o_done,
   output logic [1:0]                         o_done_resp,
   output logic                               o_err,
   input  logic                               i_err_clr,
   output logic [$clog2(MAX_OUTST+1)-1:0]     o_outst,
   output logic                               o_idle
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(MAX_OUTST + 1);
   localparam logic [PTR_W:0] PTR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

   logic [ADDR_WIDTH-1:0] r_fifoAddr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_fifoData [FIFO_DEPTH];
   logic [STRB_WIDTH-1:0] r_fifoStrb [FIFO_DEPTH];
   logic [PTR_W:0]        r_wrPtr;
   logic [PTR_W:0]        r_rdPtr;
   logic                  r_awValid;
   logic                  r_wValid;
   logic                  r_awDone;
   logic                  r_wDone;
   logic [CNT_W-1:0]      r_outst;
   logic                  r_done;
   logic [1:0]            r_doneResp;
   logic                  r_err;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_awHs;
   logic w_wHs;
   logic w_bHs;
   logic w_pop;
   logic w_issueOk;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   assign w_empty   = (r_wrPtr == r_rdPtr);
   assign w_full    = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                      (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
   assign o_wr_ready = aenable && !w_full;
   assign w_push    = i_wr_valid && o_wr_ready;
   assign w_awHs    = r_awValid && i_awready;
   assign w_wHs     = r_wValid && i_wready;
   assign o_bready  = (r_outst != '0);
   assign w_bHs     = i_bvalid && o_bready;
   // The head leaves once both channels have handshaken, counting any
   // handshake that completes on this very edge.
   assign w_pop     = (r_awDone || w_awHs) && (r_wDone || w_wHs);
   // Credit is checked before a valid rises; only the head is ever in flight.
   assign w_issueOk = aenable && !w_empty && (r_outst < CNT_MAX);

   assign o_awaddr    = r_fifoAddr[r_rdPtr[PTR_W-1:0]];
   assign o_wdata     = r_fifoData[r_rdPtr[PTR_W-1:0]];
   assign o_wstrb     = r_fifoStrb[r_rdPtr[PTR_W-1:0]];
   assign o_awprot    = 3'b000;
   assign o_awvalid   = r_awValid;
   assign o_wvalid    = r_wValid;
   assign o_done      = r_done;
   assign o_done_resp = r_doneResp;
   assign o_err       = r_err;
   assign o_outst     = r_outst;
   assign o_idle      = w_empty && (r_outst == '0) && !r_awValid && !r_wValid;

   // Request FIFO storage; cleared on reset so the head outputs read zero.
   always_ff @(posedge aclk or negedge anreset) begin
      if (!anreset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifoAddr[i] <= '0;
            r_fifoData[i] <= '0;
            r_fifoStrb[i] <= '0;
         end
      end else if (w_push) begin
         r_fifoAddr[r_wrPtr[PTR_W-1:0]] <= i_wr_addr;
         r_fifoData[r_wrPtr[PTR_W-1:0]] <= i_wr_data;
         r_fifoStrb[r_wrPtr[PTR_W-1:0]] <= i_wr_strb;
      end
   end

   // FIFO write and read pointers.
   always_ff @(posedge aclk or negedge anreset) begin
      if (!anreset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
         if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      end
   end

   // AW issue: a raised valid holds until its handshake, whatever aenable does.
   always_ff @(posedge aclk or negedge anreset) begin
      if (!anreset) begin
         r_awValid <= 1'b0;
         r_awDone  <= 1'b0;
      end else begin
         if (w_awHs)
            r_awValid <= 1'b0;
         else if (w_issueOk && !r_awDone && !r_awValid)
            r_awValid <= 1'b1;
         if (w_pop)
            r_awDone <= 1'b0;
         else if (w_awHs)
            r_awDone <= 1'b1;
      end
   end

   // W issue mirrors AW so the two channels can complete in any order.
   always_ff @(posedge aclk or negedge anreset) begin
      if (!anreset) begin
         r_wValid <= 1'b0;
         r_wDone  <= 1'b0;
      end else begin
         if (w_wHs)
            r_wValid <= 1'b0;
         else if (w_issueOk && !r_wDone && !r_wValid)
            r_wValid <= 1'b1;
         if (w_pop)
            r_wDone <= 1'b0;
         else if (w_wHs)
            r_wDone <= 1'b1;
      end
   end

   // Outstanding count: pop adds, B handshake removes, both together cancel.
   always_ff @(posedge aclk or negedge anreset) begin
      if (!anreset) begin
         r_outst <= '0;
      end else begin
         case ({w_pop, w_bHs})
            2'b10:   r_outst <= r_outst + CNT_ONE;
            2'b01:   r_outst <= r_outst - CNT_ONE;
            default: r_outst <= r_outst;
         endcase
      end
   end

   // Response report one cycle after each B handshake, plus sticky error
   // where a new error outranks a simultaneous clear.
   always_ff @(posedge aclk or negedge anreset) begin
      if (!anreset) begin
         r_done     <= 1'b0;
         r_doneResp <= 2'b00;
         r_err      <= 1'b0;
      end else begin
         r_done     <= w_bHs;
         r_doneResp <= w_bHs ? i_bresp : 2'b00;
         if (w_bHs && (i_bresp != 2'b00))
            r_err <= 1'b1;
         else if (i_err_clr)
            r_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axil_wr_master.sv
// Directed testbench for axil_wr_master with hand-computed expectations.
module tb_axil_wr_master;

   logic        aclk;
   logic        anreset;
   logic        aenable;
   logic        i_wr_valid;
   logic        o_wr_ready;
   logic [15:0] i_wr_addr;
   logic [63:0] i_wr_data;
   logic [7:0]  i_wr_strb;
   logic [15:0] o_awaddr;
   logic [2:0]  o_awprot;
   logic        o_awvalid;
   logic        i_awready;
   logic [63:0] o_wdata;
   logic [7:0]  o_wstrb;
   logic        o_wvalid;
   logic        i_wready;
   logic [1:0]  i_bresp;
   logic        i_bvalid;
   logic        o_bready;
   logic        o_done;
   logic [1:0]  o_done_resp;
   logic        o_err;
   logic        i_err_clr;
   logic [2:0]  o_outst;
   logic        o_idle;

   int checkCount = 0;
   int errorCount = 0;
   int awCount    = 0;
   int doneCount  = 0;

   axil_wr_master #(
      .ADDR_WIDTH(16), .DATA_WIDTH(64), .STRB_WIDTH(8),
      .FIFO_DEPTH(4), .MAX_OUTST(4)
   ) dut (
      .aclk(aclk), .anreset(anreset), .aenable(aenable),
      .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
      .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wr_strb(i_wr_strb),
      .o_awaddr(o_awaddr), .o_awprot(o_awprot), .o_awvalid(o_awvalid),
      .i_awready(i_awready),
      .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid),
      .i_wready(i_wready),
      .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
      .o_done(o_done), .o_done_resp(o_done_resp), .o_err(o_err),
      .i_err_clr(i_err_clr), .o_outst(o_outst), .o_idle(o_idle)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Count AW handshakes and done pulses seen on the bus.
   always @(posedge aclk) begin
      if (anreset && o_awvalid && i_awready) awCount++;
      if (anreset && o_done) doneCount++;
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Offer one request and hold it until accepted (bounded).
   task automatic applyStimulus(input logic [15:0] a, input logic [63:0] d,
                                input logic [7:0] s);
      int waitCycles = 0;
      i_wr_valid = 1'b1;
      i_wr_addr  = a;
      i_wr_data  = d;
      i_wr_strb  = s;
      while (!o_wr_ready && waitCycles < 50) begin
         tick();
         waitCycles++;
      end
      checkOutput("push_accept", {63'd0, o_wr_ready}, 64'd1);
      tick();
      i_wr_valid = 1'b0;
   endtask

   task automatic waitOutst(input logic [2:0] target, input int budget);
      int n = 0;
      while (o_outst != target && n < budget) begin
         tick();
         n++;
      end
      checkOutput("outst_reach", {61'd0, o_outst}, {61'd0, target});
   endtask

   task automatic drainDone(input int target, input int budget);
      int n = 0;
      i_bvalid = 1'b1;
      i_bresp  = 2'b00;
      while (doneCount < target && n < budget) begin
         tick();
         n++;
      end
      tick();
      tick();
      i_bvalid = 1'b0;
      checkOutput("drain_done", 64'(doneCount), 64'(target));
   endtask

   initial begin
      int awBase;
      int doneBase;
      int n;
      anreset    = 1'b0;
      aenable    = 1'b0;
      i_wr_valid = 1'b0;
      i_wr_addr  = '0;
      i_wr_data  = '0;
      i_wr_strb  = '0;
      i_awready  = 1'b0;
      i_wready   = 1'b0;
      i_bresp    = 2'b00;
      i_bvalid   = 1'b0;
      i_err_clr  = 1'b0;

      // Reset values
      #3;
      checkOutput("rst_ready_off", {63'd0, o_wr_ready}, 64'd0);
      aenable = 1'b1;
      #1;
      checkOutput("rst_ready_on", {63'd0, o_wr_ready}, 64'd1);
      checkOutput("rst_awvalid", {63'd0, o_awvalid}, 64'd0);
      checkOutput("rst_wvalid", {63'd0, o_wvalid}, 64'd0);
      checkOutput("rst_bready", {63'd0, o_bready}, 64'd0);
      checkOutput("rst_done", {63'd0, o_done}, 64'd0);
      checkOutput("rst_err", {63'd0, o_err}, 64'd0);
      checkOutput("rst_outst", {61'd0, o_outst}, 64'd0);
      checkOutput("rst_awaddr", {48'd0, o_awaddr}, 64'd0);
      checkOutput("rst_wdata", o_wdata, 64'd0);
      checkOutput("rst_idle", {63'd0, o_idle}, 64'd1);
      #8;
      anreset = 1'b1;
      tick();

      // Single write with ready slaves
      $display("[TB] single write");
      i_awready = 1'b1;
      i_wready  = 1'b1;
      applyStimulus(16'h0040, 64'h1122334455667788, 8'hFF);
      checkOutput("sw_c1_awvalid", {63'd0, o_awvalid}, 64'd0);
      tick();
      checkOutput("sw_c2_awvalid", {63'd0, o_awvalid}, 64'd1);
      checkOutput("sw_c2_wvalid", {63'd0, o_wvalid}, 64'd1);
      checkOutput("sw_awaddr", {48'd0, o_awaddr}, 64'h0040);
      checkOutput("sw_wdata", o_wdata, 64'h1122334455667788);
      checkOutput("sw_wstrb", {56'd0, o_wstrb}, 64'hFF);
      checkOutput("sw_awprot", {61'd0, o_awprot}, 64'd0);
      tick();
      checkOutput("sw_c3_awvalid", {63'd0, o_awvalid}, 64'd0);
      checkOutput("sw_c3_wvalid", {63'd0, o_wvalid}, 64'd0);
      checkOutput("sw_c3_outst", {61'd0, o_outst}, 64'd1);
      checkOutput("sw_c3_bready", {63'd0, o_bready}, 64'd1);
      i_bvalid = 1'b1;
      tick();
      i_bvalid = 1'b0;
      checkOutput("sw_done", {63'd0, o_done}, 64'd1);
      checkOutput("sw_done_resp", {62'd0, o_done_resp}, 64'd0);
      checkOutput("sw_outst0", {61'd0, o_outst}, 64'd0);
      checkOutput("sw_idle", {63'd0, o_idle}, 64'd1);
      tick();
      checkOutput("sw_done_pulse", {63'd0, o_done}, 64'd0);

      // AW/W skew: AW slave waits, W slave ready
      $display("[TB] aw/w skew");
      i_awready = 1'b0;
      applyStimulus(16'h1234, 64'hCAFEBABE00000001, 8'h0F);
      tick();
      for (int i = 0; i < 4; i++) begin
         checkOutput("skew_awvalid", {63'd0, o_awvalid}, 64'd1);
         checkOutput("skew_wvalid", {63'd0, o_wvalid}, (i == 0) ? 64'd1 : 64'd0);
         checkOutput("skew_awaddr", {48'd0, o_awaddr}, 64'h1234);
         checkOutput("skew_wdata", o_wdata, 64'hCAFEBABE00000001);
         checkOutput("skew_outst", {61'd0, o_outst}, 64'd0);
         tick();
      end
      checkOutput("skew_c6_awvalid", {63'd0, o_awvalid}, 64'd1);
      i_awready = 1'b1;
      tick();
      checkOutput("skew_c7_awvalid", {63'd0, o_awvalid}, 64'd0);
      checkOutput("skew_c7_wvalid", {63'd0, o_wvalid}, 64'd0);
      checkOutput("skew_c7_outst", {61'd0, o_outst}, 64'd1);
      doneBase = doneCount;
      drainDone(doneBase + 1, 20);
      checkOutput("skew_idle", {63'd0, o_idle}, 64'd1);

      // Credit limit: six writes, B withheld
      $display("[TB] credit limit");
      awBase   = awCount;
      doneBase = doneCount;
      for (int i = 0; i < 6; i++)
         applyStimulus(16'h0100 + 16'(i * 8), 64'(i + 100), 8'hFF);
      for (int i = 0; i < 12; i++) tick();
      checkOutput("credit_aw4", 64'(awCount - awBase), 64'd4);
      checkOutput("credit_outst4", {61'd0, o_outst}, 64'd4);
      checkOutput("credit_awvalid", {63'd0, o_awvalid}, 64'd0);
      checkOutput("credit_wvalid", {63'd0, o_wvalid}, 64'd0);
      checkOutput("credit_head", {48'd0, o_awaddr}, 64'h0120);
      drainDone(doneBase + 6, 100);
      checkOutput("credit_aw6", 64'(awCount - awBase), 64'd6);
      checkOutput("credit_outst0", {61'd0, o_outst}, 64'd0);
      checkOutput("credit_idle", {63'd0, o_idle}, 64'd1);

      // FIFO full with AW slave stalled; stray B while nothing outstanding
      $display("[TB] fifo full");
      i_bvalid = 1'b1;
      tick();
      i_bvalid = 1'b0;
      checkOutput("stray_b_done", {63'd0, o_done}, 64'd0);
      i_awready = 1'b0;
      doneBase  = doneCount;
      for (int i = 0; i < 4; i++) begin
         i_wr_valid = 1'b1;
         i_wr_addr  = 16'h0200 + 16'(i);
         i_wr_data  = 64'(i + 200);
         checkOutput("full_ready", {63'd0, o_wr_ready}, 64'd1);
         tick();
      end
      i_wr_addr = 16'h0204;
      i_wr_data = 64'd204;
      for (int i = 0; i < 3; i++) begin
         checkOutput("full_blocked", {63'd0, o_wr_ready}, 64'd0);
         tick();
      end
      checkOutput("full_head_aw", {63'd0, o_awvalid}, 64'd1);
      checkOutput("full_head_w", {63'd0, o_wvalid}, 64'd0);
      checkOutput("full_pop_cycle_rdy", {63'd0, o_wr_ready}, 64'd0);
      i_awready = 1'b1;
      tick();
      checkOutput("full_after_pop_rdy", {63'd0, o_wr_ready}, 64'd1);
      tick();
      i_wr_valid = 1'b0;
      drainDone(doneBase + 5, 200);
      checkOutput("full_idle", {63'd0, o_idle}, 64'd1);

      // Error reporting and set-beats-clear
      $display("[TB] error");
      for (int i = 0; i < 3; i++)
         applyStimulus(16'h0300 + 16'(i), 64'(i + 300), 8'hF0);
      waitOutst(3'd3, 30);
      i_bvalid = 1'b1;
      i_bresp  = 2'b00;
      tick();
      checkOutput("err_r1_resp", {62'd0, o_done_resp}, 64'd0);
      checkOutput("err_r1_err", {63'd0, o_err}, 64'd0);
      i_bresp = 2'b10;
      tick();
      checkOutput("err_r2_resp", {62'd0, o_done_resp}, 64'd2);
      checkOutput("err_r2_err", {63'd0, o_err}, 64'd1);
      i_bresp   = 2'b11;
      i_err_clr = 1'b1;
      tick();
      i_bvalid  = 1'b0;
      i_bresp   = 2'b00;
      checkOutput("err_r3_resp", {62'd0, o_done_resp}, 64'd3);
      checkOutput("err_set_wins", {63'd0, o_err}, 64'd1);
      tick();
      i_err_clr = 1'b0;
      checkOutput("err_cleared", {63'd0, o_err}, 64'd0);

      // Asynchronous reset mid-transaction
      $display("[TB] reset mid-flight");
      for (int i = 0; i < 3; i++)
         applyStimulus(16'h0400 + 16'(i), 64'(i + 400), 8'h3C);
      n = 0;
      while (!(o_outst == 3'd2 && o_awvalid) && n < 30) begin
         tick();
         n++;
      end
      checkOutput("rstm_pre_aw", {63'd0, o_awvalid}, 64'd1);
      checkOutput("rstm_pre_outst", {61'd0, o_outst}, 64'd2);
      #2;
      anreset = 1'b0;
      #1;
      checkOutput("rstm_awvalid", {63'd0, o_awvalid}, 64'd0);
      checkOutput("rstm_wvalid", {63'd0, o_wvalid}, 64'd0);
      checkOutput("rstm_outst", {61'd0, o_outst}, 64'd0);
      checkOutput("rstm_bready", {63'd0, o_bready}, 64'd0);
      checkOutput("rstm_awaddr", {48'd0, o_awaddr}, 64'd0);
      #2;
      anreset = 1'b1;
      tick();
      checkOutput("rstm_idle", {63'd0, o_idle}, 64'd1);
      checkOutput("rstm_outst_after", {61'd0, o_outst}, 64'd0);
      checkOutput("rstm_awvalid_after", {63'd0, o_awvalid}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
